uart_apb_wait_interface: RTL
============================

Name: uart_apb_wait_interface

Overview:
- Parametrised APB slave front-end for the UART register block.
- Converts APB transfers into regfile write/read controls and TX/RX FIFO strobes.
- Inserts APB wait states (PREADY low) when software writes TX_DATA while the TX FIFO is full, or reads RX_DATA while the RX FIFO is empty.
- A bounded timeout completes a stalled transfer with PSLVERR. The regfile is external, connected through the reg_* ports.

Parameters:
- ADDR_W, 5, APB address width.
- DATA_W, 32, APB data width (>= 8).
- MAX_ADDR, 5'h10, highest legal register offset.
- TX_DATA_ADDR, `UART_TX_DATA_ADDR, TX data register offset.
- RX_DATA_ADDR, `UART_RX_DATA_ADDR, RX data register offset.
- TIMEOUT_CYCLES, 16, wait cycles allowed before error completion (>= 1).

Ports:
- pclk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- psel_i / penable_i / pwrite_i  in  1 each  APB controls
- paddr_i  in  ADDR_W  APB address
- pwdata_i  in  DATA_W  APB write data
- prdata_o  out  DATA_W  APB read data
- pready_o  out  1  APB ready
- pslverr_o  out  1  APB error
- reg_we_o  out  1  regfile write strobe
- reg_addr_o  out  ADDR_W  regfile address (= paddr_i)
- reg_wdata_o  out  DATA_W  regfile write data (= pwdata_i)
- reg_rdata_i  in  DATA_W  regfile read data (combinational)
- tx_fifo_full_i  in  1  TX FIFO full
- tx_fifo_wen_o  out  1  TX push strobe
- tx_fifo_wdata_o  out  8  TX push data (= pwdata_i[7:0])
- rx_fifo_empty_i  in  1  RX FIFO empty
- rx_fifo_rdata_i  in  8  RX head byte (first-word fall-through)
- rx_fifo_ren_o  out  1  RX pop strobe
- wait_active_o  out  1  high while in WAIT

Behaviour:
- Definitions:
  - access = psel_i & penable_i.
  - bad_addr = paddr_i > MAX_ADDR.
  - blk = (pwrite_i & paddr_i==TX_DATA_ADDR & tx_fifo_full_i) | (!pwrite_i & paddr_i==RX_DATA_ADDR & rx_fifo_empty_i).
- FSM states: IDLE, WAIT. Wait counter cnt has width clog2(TIMEOUT_CYCLES+1).
- Reset: state=IDLE, cnt=0.
  - Outputs are combinational from state. Out of reset: pready_o=1, pslverr_o=0, all strobes 0, wait_active_o=0, prdata_o=0.
- IDLE, no access: pready_o=1, pslverr_o=0, strobes 0, prdata_o=0.
- IDLE, access, bad_addr:
  - pready_o=1, pslverr_o=1, zero wait states.
  - No reg_we_o, no FIFO strobes. prdata_o=0.
- IDLE, access, !bad_addr, !blk: complete same cycle, zero wait states, pready_o=1.
  - Write: reg_we_o=1. tx_fifo_wen_o=1 if paddr_i==TX_DATA_ADDR.
  - Read: prdata_o = RX_DATA_ADDR ? zero-extended rx_fifo_rdata_i : reg_rdata_i. rx_fifo_ren_o=1 if paddr_i==RX_DATA_ADDR.
- IDLE, access, !bad_addr, blk: pready_o=0, no strobes, next state WAIT, cnt<=0.
- WAIT (wait_active_o=1), evaluated each cycle:
  - blk clear: complete exactly as the IDLE non-blocked case (pready_o=1, strobes/prdata as above), then go to IDLE.
  - Else if cnt==TIMEOUT_CYCLES-1: pready_o=1, pslverr_o=1, no strobes, prdata_o=0, then go to IDLE.
  - Else: pready_o=0, cnt<=cnt+1.
  - If blk clears on the same cycle the timeout is reached, success wins.
  - psel_i low in WAIT (master protocol violation): abort to IDLE, no side effects, pready_o=1.
- Timing: a transfer that stalls to timeout has an access phase of TIMEOUT_CYCLES+1 cycles. A stall released after n WAIT cycles has n+1.
- Strobes: each strobe is high for exactly one cycle per transfer and only on the completing cycle. Never more than one push or pop per transfer.
- Reset mid-WAIT: takes priority. Next cycle is IDLE with cnt=0 and no strobes. The pending transfer is dropped.
- prdata_o=0 whenever pready_o=0 or the transfer is a write.

Optional Feature:
- Macro: UART_APB_WAIT_EN.
- Defined: blocking wait-state behaviour as above.
- Undefined:
  - WAIT state and counter are removed. blk is never a stall cause; every transfer completes in its first access cycle.
  - Blocked TX write: pslverr_o=1, tx_fifo_wen_o=0, reg_we_o=0.
  - Blocked RX read: pslverr_o=1, rx_fifo_ren_o=0, prdata_o=0.
  - wait_active_o tied 0.

Test Plan:
- Reset, then idle -> pready_o=1, pslverr_o=0, all strobes 0, prdata_o=0.
- Write 0xA5 to TX_DATA, tx_fifo_full_i=0 -> same-cycle pready_o=1, tx_fifo_wen_o=1 for one cycle, tx_fifo_wdata_o=0xA5, pslverr_o=0.
- Write TX_DATA with full=1, deassert full after 3 WAIT cycles -> pready_o low 4 cycles, then high with tx_fifo_wen_o=1, pslverr_o=0.
- Read RX_DATA with empty held 1 -> PREADY low for 16 cycles, completes on the 17th access cycle with pslverr_o=1, rx_fifo_ren_o never asserted, prdata_o=0.
- Read paddr=5'h14 -> pready_o=1 first cycle, pslverr_o=1, no strobes. Read RX_DATA with empty=0, rdata=0x3C -> prdata_o=0x0000003C, rx_fifo_ren_o=1.
- Assert reset_i during WAIT cycle 5 -> next cycle IDLE, wait_active_o=0, no strobes. With UART_APB_WAIT_EN undefined, full TX write -> single-cycle pslverr_o=1, tx_fifo_wen_o=0.

Source files
------------

// File: rtl/uart_apb_wait_interface.sv
// uart_apb_wait_interface: APB slave front-end for the UART regfile and FIFOs, FIFO wait states enabled by UART_APB_WAIT_EN
`ifndef UART_TX_DATA_ADDR
`define UART_TX_DATA_ADDR 5'h00
`endif
`ifndef UART_RX_DATA_ADDR
`define UART_RX_DATA_ADDR 5'h04
`endif
module uart_apb_wait_interface #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 5'h10,
  parameter logic [ADDR_W-1:0] TX_DATA_ADDR = `UART_TX_DATA_ADDR,
  parameter logic [ADDR_W-1:0] RX_DATA_ADDR = `UART_RX_DATA_ADDR,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk_i,
  input  logic              reset_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  input  logic              tx_fifo_full_i,
  output logic              tx_fifo_wen_o,
  output logic [7:0]        tx_fifo_wdata_o,
  input  logic              rx_fifo_empty_i,
  input  logic [7:0]        rx_fifo_rdata_i,
  output logic              rx_fifo_ren_o,
  output logic              wait_active_o
);
  logic access, bad_addr, is_tx, is_rx, blk, ok, err;
  logic [DATA_W-1:0] rx_ext;
  assign access = psel_i & penable_i;
  assign bad_addr = paddr_i > MAX_ADDR;
  assign is_tx = paddr_i == TX_DATA_ADDR;
  assign is_rx = paddr_i == RX_DATA_ADDR;
  assign blk = (pwrite_i & is_tx & tx_fifo_full_i) | (!pwrite_i & is_rx & rx_fifo_empty_i);
  assign reg_addr_o = paddr_i;
  assign reg_wdata_o = pwdata_i;
  assign tx_fifo_wdata_o = pwdata_i[7:0];
  always_comb begin
    rx_ext = '0;
    rx_ext[7:0] = rx_fifo_rdata_i;
  end
`ifdef UART_APB_WAIT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic live, stall, tmo;
  always_ff @(posedge pclk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    live = state_q == S_WAIT ? psel_i : access;
    stall = live & !bad_addr & blk;
    tmo = stall & state_q == S_WAIT & cnt_q == LAST;
    state_d = stall & !tmo ? S_WAIT : S_IDLE;
    cnt_d = stall & !tmo & state_q == S_WAIT ? cnt_q + CW'(1) : '0;
  end
  always_comb begin
    ok = live & !bad_addr & !blk;
    err = (live & bad_addr) | tmo;
    pready_o = !stall | tmo;
    wait_active_o = state_q == S_WAIT;
  end
`else
  logic unused_clk;
  assign unused_clk = &{1'b0, pclk_i, reset_i};
  always_comb begin
    ok = access & !bad_addr & !blk;
    err = access & (bad_addr | blk);
    pready_o = 1'b1;
    wait_active_o = 1'b0;
  end
`endif
  always_comb begin
    reg_we_o = ok & pwrite_i;
    tx_fifo_wen_o = ok & pwrite_i & is_tx;
    rx_fifo_ren_o = ok & !pwrite_i & is_rx;
    pslverr_o = err;
    prdata_o = ok & !pwrite_i ? (is_rx ? rx_ext : reg_rdata_i) : '0;
  end
endmodule
